// File: rtl/stats_collect_flush_pkg.sv
// Shared constants for the statistics collector: scanner state encoding and
// accumulator sizing helper.
package stats_collect_flush_pkg;

    localparam logic [0:0] SCAN_READ  = 1'b0;
    localparam logic [0:0] SCAN_WRITE = 1'b1;

    // Wide enough to absorb 2*COUNT cycles of full-scale increments between folds.
    function automatic int acc_width(input int inc_width, input int count);
        return inc_width + $clog2(count) + 1;
    endfunction

endpackage

// File: rtl/stats_collect_flush_acc_channel.sv
// One narrow per-channel accumulator; on its clear cycle it restarts from the
// same-cycle increment so no increment is lost across a fold.
module stats_acc_channel #(
    parameter int INC_WIDTH = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 valid,
    input  logic                 en,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] acc
);

    logic [ACC_WIDTH-1:0] inc_ext;

    assign inc_ext = (valid && en) ? ACC_WIDTH'(inc) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= inc_ext;
        end else begin
            acc <= acc + inc_ext;
        end
    end

endmodule

// File: rtl/stats_collect_flush.sv
// Statistics collector: per-channel accumulators folded round-robin into a RAM bank,
// emitted as (id, delta) stream records on update, flush, period expiry or threshold.
module stats_collect_flush
    import stats_collect_flush_pkg::*;
#(
    parameter int COUNT          = 8,
    parameter int INC_WIDTH      = 8,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = $clog2(COUNT),
    parameter int BASE_ID        = 0,
    parameter int UPDATE_PERIOD  = 1024,
    parameter int THRESH_BIT     = STAT_INC_WIDTH - 1,
    parameter int SATURATE       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INC_WIDTH*COUNT-1:0] stat_inc,
    input  logic [COUNT-1:0]           stat_valid,
    input  logic [COUNT-1:0]           stat_en,
    output logic [STAT_INC_WIDTH-1:0]  m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH-1:0]   m_axis_stat_tid,
    output logic                       m_axis_stat_tvalid,
    input  logic                       m_axis_stat_tready,
    input  logic                       update,
    input  logic                       flush,
    output logic                       flush_busy,
    output logic                       flush_done,
    output logic [COUNT-1:0]           overflow,
    input  logic [COUNT-1:0]           overflow_clr
);

    localparam int ACC_WIDTH = acc_width(INC_WIDTH, COUNT);
    localparam int IDX_W     = $clog2(COUNT);
    localparam int PER_W     = $clog2(UPDATE_PERIOD);

    if (COUNT > (1 << STAT_ID_WIDTH)) begin : g_bad_id_width
        $fatal(1, "STAT_ID_WIDTH too narrow for COUNT");
    end

    function automatic logic [STAT_INC_WIDTH-1:0] sat_fold(input logic [STAT_INC_WIDTH:0] s);
        if (s[STAT_INC_WIDTH] && (SATURATE != 0)) return '1;
        return s[STAT_INC_WIDTH-1:0];
    endfunction

    logic [ACC_WIDTH-1:0]      acc [COUNT];
    logic [STAT_INC_WIDTH-1:0] ram [COUNT];
    logic [COUNT-1:0]          acc_clear;
    logic [COUNT-1:0]          ovf_set;
    logic [COUNT-1:0]          zero;
    logic [COUNT-1:0]          due;
    logic [0:0]                scan_state;
    logic [IDX_W-1:0]          scan_idx;
    logic [PER_W-1:0]          period_cnt;
    logic                      reload;
    logic [STAT_INC_WIDTH-1:0] ram_rd_p1;
    logic [STAT_INC_WIDTH-1:0] ram_eff_p1;
    logic [STAT_INC_WIDTH:0]   sum_p1;
    logic [STAT_INC_WIDTH-1:0] fold_p1;
    logic                      emit_p1;

    for (genvar g = 0; g < COUNT; g++) begin : g_ch
        stats_acc_channel #(
            .INC_WIDTH (INC_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (stat_inc[g*INC_WIDTH +: INC_WIDTH]),
            .valid (stat_valid[g]),
            .en    (stat_en[g]),
            .clear (acc_clear[g]),
            .acc   (acc[g])
        );
    end

    // Fold stage: RAM word latched in READ is combined with the live accumulator in WRITE.
    assign ram_eff_p1 = zero[scan_idx] ? '0 : ram_rd_p1;
    assign sum_p1     = {1'b0, ram_eff_p1} + (STAT_INC_WIDTH+1)'(acc[scan_idx]);
    assign fold_p1    = sat_fold(sum_p1);
    assign emit_p1    = (scan_state == SCAN_WRITE) && !m_axis_stat_tvalid &&
                        (due[scan_idx] || ram_eff_p1[THRESH_BIT]);
    assign reload     = (period_cnt == '0) || update || flush;

    always_comb begin
        acc_clear = '0;
        ovf_set   = '0;
        if (scan_state == SCAN_WRITE) begin
            acc_clear[scan_idx] = 1'b1;
            ovf_set[scan_idx]   = sum_p1[STAT_INC_WIDTH];
        end
    end

    // RAM bank carries no reset; zero[] hides stale words after reset.
    always_ff @(posedge clk) begin
        if (scan_state == SCAN_READ) begin
            ram_rd_p1 <= ram[scan_idx];
        end else begin
            ram[scan_idx] <= emit_p1 ? '0 : fold_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_state <= SCAN_READ;
            scan_idx   <= '0;
            zero       <= '1;
        end else if (scan_state == SCAN_READ) begin
            scan_state <= SCAN_WRITE;
        end else begin
            scan_state       <= SCAN_READ;
            zero[scan_idx]   <= 1'b0;
            scan_idx         <= (scan_idx == IDX_W'(COUNT-1)) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    // A re-arm in the same cycle as an emit wins, so the channel is swept again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            due        <= '0;
            period_cnt <= PER_W'(UPDATE_PERIOD-1);
        end else begin
            period_cnt <= reload ? PER_W'(UPDATE_PERIOD-1) : period_cnt - PER_W'(1);
            if (reload) begin
                due <= '1;
            end else if (emit_p1) begin
                due[scan_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_stat_tvalid <= 1'b0;
            m_axis_stat_tdata  <= '0;
            m_axis_stat_tid    <= '0;
        end else if (emit_p1) begin
            m_axis_stat_tvalid <= (fold_p1 != '0);
            m_axis_stat_tdata  <= fold_p1;
            m_axis_stat_tid    <= STAT_ID_WIDTH'(BASE_ID) + STAT_ID_WIDTH'(scan_idx);
        end else if (m_axis_stat_tvalid && m_axis_stat_tready) begin
            m_axis_stat_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            overflow   <= '0;
        end else begin
            flush_done <= 1'b0;
            overflow   <= (overflow & ~overflow_clr) | ovf_set;
            if (flush) begin
                flush_busy <= 1'b1;
            end else if (flush_busy && (due == '0) && !m_axis_stat_tvalid) begin
                flush_busy <= 1'b0;
                flush_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stats_collect_flush.sv
// Directed bench for stats_collect_flush: two instances (saturating/base 0 and
// wrapping/base 16/short period) checked against a per-channel conservation model.
module tb_stats_collect_flush;

    localparam int C = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [C*8-1:0] stat_inc = '0;
    logic [C-1:0]  stat_valid = '0;
    logic [C-1:0]  stat_en = '1;
    logic          tready = 1'b1;
    logic          update = 1'b0;
    logic          flush = 1'b0;
    logic [C-1:0]  overflow_clr = '0;

    logic [15:0]   tdata_w [2];
    logic [2:0]    tid_a;
    logic [4:0]    tid_b;
    logic [4:0]    tid_w [2];
    logic          tvalid_w [2];
    logic          busy_w [2];
    logic          done_w [2];
    logic [C-1:0]  ovf_w [2];

    assign tid_w[0] = {2'b00, tid_a};
    assign tid_w[1] = tid_b;

    always #5 clk = ~clk;

    stats_collect_flush #(
        .COUNT(C), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .STAT_ID_WIDTH(3), .BASE_ID(0),
        .UPDATE_PERIOD(1024), .THRESH_BIT(15), .SATURATE(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .stat_inc(stat_inc), .stat_valid(stat_valid), .stat_en(stat_en),
        .m_axis_stat_tdata(tdata_w[0]), .m_axis_stat_tid(tid_a), .m_axis_stat_tvalid(tvalid_w[0]),
        .m_axis_stat_tready(tready), .update(update), .flush(flush), .flush_busy(busy_w[0]),
        .flush_done(done_w[0]), .overflow(ovf_w[0]), .overflow_clr(overflow_clr)
    );

    stats_collect_flush #(
        .COUNT(C), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .STAT_ID_WIDTH(5), .BASE_ID(16),
        .UPDATE_PERIOD(64), .THRESH_BIT(15), .SATURATE(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .stat_inc(stat_inc), .stat_valid(stat_valid), .stat_en(stat_en),
        .m_axis_stat_tdata(tdata_w[1]), .m_axis_stat_tid(tid_b), .m_axis_stat_tvalid(tvalid_w[1]),
        .m_axis_stat_tready(tready), .update(update), .flush(flush), .flush_busy(busy_w[1]),
        .flush_done(done_w[1]), .overflow(ovf_w[1]), .overflow_clr(overflow_clr)
    );

    typedef struct { int id; int data; } rec_t;

    rec_t        recs_a [$];
    rec_t        recs_b [$];
    longint      total [2][C];
    longint      recv  [2][C];
    int          done_cnt [2];
    int          checks = 0;
    int          errors = 0;

    logic        pv [2];
    logic [15:0] pd [2];
    logic [4:0]  pi [2];
    logic        pb [2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int first_data(input int d, input int id);
        if (d == 0) begin
            foreach (recs_a[i]) if (recs_a[i].id == id) return recs_a[i].data;
        end else begin
            foreach (recs_b[i]) if (recs_b[i].id == id) return recs_b[i].data;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < C; ch++) begin
                total[d][ch] = 0;
                recv[d][ch]  = 0;
            end
        recs_a.delete();
        recs_b.delete();
    endtask

    // Model and per-cycle protocol checks, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            int base;
            base = (d == 0) ? 0 : 16;
            if (!rst_n) begin
                pv[d] = 1'b0;
                pb[d] = 1'b0;
            end else begin
                if (pv[d] && tready) begin
                    rec_t r;
                    r.id   = int'(pi[d]) - base;
                    r.data = int'(pd[d]);
                    if (r.id >= 0 && r.id < C) recv[d][r.id] += r.data;
                    if (d == 0) recs_a.push_back(r);
                    else        recs_b.push_back(r);
                end
                if (pv[d] && !tready)
                    chk($sformatf("hold_dut%0d", d), {tvalid_w[d], tdata_w[d], tid_w[d]},
                        {1'b1, pd[d], pi[d]});
                if (tvalid_w[d])
                    chk($sformatf("record_sane_dut%0d", d),
                        (int'(tid_w[d]) >= base && int'(tid_w[d]) < base + C && tdata_w[d] != 0), 1);
                if (done_w[d]) begin
                    chk($sformatf("done_edge_dut%0d", d), {pb[d], busy_w[d]}, 2'b10);
                    done_cnt[d]++;
                end
                pv[d] = tvalid_w[d];
                pd[d] = tdata_w[d];
                pi[d] = tid_w[d];
                pb[d] = busy_w[d];
            end
        end
        if (rst_n)
            for (int ch = 0; ch < C; ch++)
                if (stat_valid[ch] && stat_en[ch]) begin
                    total[0][ch] += stat_inc[ch*8 +: 8];
                    total[1][ch] += stat_inc[ch*8 +: 8];
                end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic inc_run(input int ch, input int val, input int cycles);
        stat_inc[ch*8 +: 8] = val[7:0];
        stat_valid[ch] = 1'b1;
        tick(cycles);
        stat_valid[ch] = 1'b0;
    endtask

    task automatic drain_sync(input int skip);
        int n;
        tready = 1'b1;
        pulse_flush();
        n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n < 400), 1);
        tick(2);
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < C; ch++)
                if (ch != skip)
                    chk($sformatf("conserve_dut%0d_ch%0d", d, ch), recv[d][ch], total[d][ch]);
    endtask

    initial begin
        int n;
        int dprev;
        int sum;
        bit all16;
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0;
            pv[d] = 1'b0;
            pb[d] = 1'b0;
        end
        clear_model();
        tick(3);
        rst_n = 1'b1;
        tick(1);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_tvalid_dut%0d", d), tvalid_w[d], 0);
            chk($sformatf("reset_tdata_dut%0d", d), tdata_w[d], 0);
            chk($sformatf("reset_tid_dut%0d", d), tid_w[d], 0);
            chk($sformatf("reset_busy_dut%0d", d), busy_w[d], 0);
            chk($sformatf("reset_done_dut%0d", d), done_w[d], 0);
            chk($sformatf("reset_overflow_dut%0d", d), ovf_w[d], 0);
        end

        // ch3: ten increments of 5, then one update -> a single record of 50
        inc_run(3, 5, 10);
        tick(2);
        pulse_update();
        tick(3*C + 4);
        chk("model_total_ch3", total[0][3], 50);
        chk("upd_rec_count", recs_a.size(), 1);
        chk("upd_rec_tid3", first_data(0, 3), 50);
        drain_sync(-1);
        chk("upd_rec_count_after_flush", recs_a.size(), 1);

        // ch4 disabled halfway: only the enabled increments count
        recs_a.delete(); recs_b.delete();
        stat_inc[4*8 +: 8] = 8'd3;
        stat_valid[4] = 1'b1;
        tick(4);
        stat_en[4] = 1'b0;
        tick(4);
        stat_valid[4] = 1'b0;
        stat_en[4] = 1'b1;
        drain_sync(-1);
        chk("en_rec_count", recs_a.size(), 1);
        chk("en_rec_ch4", first_data(0, 4), 12);

        // ch2 reaches 0x8000 with no request: threshold forces the emit
        pulse_update();
        tick(2*C + 4);
        recs_a.delete(); recs_b.delete();
        inc_run(2, 128, 256);
        n = 0;
        while (recs_a.size() == 0 && n < 4*C + 8) begin
            @(negedge clk);
            n++;
        end
        chk("thresh_emitted_in_time", (recs_a.size() == 1), 1);
        chk("thresh_rec_ch2", first_data(0, 2), 32768);
        drain_sync(-1);

        // flush with ch0=7 and ch5=9 while tready toggles
        recs_a.delete(); recs_b.delete();
        stat_inc[0 +: 8] = 8'd7;
        stat_inc[40 +: 8] = 8'd9;
        stat_valid = 8'h21;
        tick(1);
        stat_valid = '0;
        tick(2);
        dprev = done_cnt[0];
        pulse_flush();
        chk("flush_busy_rise", busy_w[0], 1);
        n = 0;
        while (busy_w[0] && n < 200) begin
            @(negedge clk);
            tready = ~tready;
            n++;
        end
        chk("flush_busy_fall_in_time", (n < 200), 1);
        chk("flush_recs_before_fall", recs_a.size(), 2);
        tready = 1'b1;
        tick(2);
        chk("flush_done_pulses", done_cnt[0] - dprev, 1);
        chk("flush_rec_ch0", first_data(0, 0), 7);
        chk("flush_rec_ch5", first_data(0, 5), 9);

        // flush with nothing accrued: completes quickly with no records
        recs_a.delete(); recs_b.delete();
        dprev = done_cnt[0];
        pulse_flush();
        n = 0;
        while (done_cnt[0] == dprev && n < 2*C + 2) begin
            @(negedge clk);
            n++;
        end
        chk("flush_zero_done", done_cnt[0] - dprev, 1);
        chk("flush_zero_norec", recs_a.size(), 0);
        drain_sync(-1);

        // overflow: output blocked by a ch0 record while ch1 piles up 5000 x 255
        recs_a.delete(); recs_b.delete();
        tready = 1'b0;
        inc_run(0, 7, 1);
        pulse_update();
        tick(2*C + 4);
        chk("blocked_tvalid_dut0", tvalid_w[0], 1);
        chk("blocked_tvalid_dut1", tvalid_w[1], 1);
        chk("blocked_rec_dut0", {tid_w[0], tdata_w[0]}, {5'd0, 16'd7});
        inc_run(1, 255, 5000);
        tick(3*C);
        chk("model_total_ch1", total[0][1], 1275000);
        chk("ovf_sat_dut0", ovf_w[0], 8'h02);
        chk("ovf_wrap_dut1", ovf_w[1], 8'h02);
        tready = 1'b1;
        tick(6*C);
        chk("sat_first_rec", recs_a[0].id, 0);
        chk("sat_rec_ch1", first_data(0, 1), 65535);
        chk("wrap_rec_ch1", first_data(1, 1), 29816);
        overflow_clr[1] = 1'b1;
        tick(1);
        overflow_clr = '0;
        chk("ovf_clr_dut0", ovf_w[0], 0);
        chk("ovf_clr_dut1", ovf_w[1], 0);
        drain_sync(1);
        recv[0][1] = total[0][1];
        recv[1][1] = total[1][1];

        // periodic emission on the short-period instance, ch0 +1 every cycle
        recs_a.delete(); recs_b.delete();
        inc_run(0, 1, 300);
        chk("no_spontaneous_dut0", recs_a.size(), 0);
        chk("periodic_recs_seen", (recs_b.size() >= 3), 1);
        drain_sync(-1);
        sum = 0;
        all16 = 1'b1;
        foreach (recs_b[i]) begin
            sum += recs_b[i].data;
            if (recs_b[i].id != 0) all16 = 1'b0;
        end
        chk("periodic_all_tid16", all16, 1);
        chk("periodic_sum", sum, 300);

        // reset while a record is held: tvalid drops at once, nothing stale afterwards
        tready = 1'b0;
        inc_run(6, 20, 1);
        pulse_update();
        tick(2*C + 4);
        chk("pre_reset_tvalid", tvalid_w[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tvalid_dut0", tvalid_w[0], 0);
        chk("async_reset_tvalid_dut1", tvalid_w[1], 0);
        clear_model();
        tick(3);
        rst_n = 1'b1;
        tready = 1'b1;
        tick(4*C);
        pulse_update();
        tick(3*C);
        chk("post_reset_norec_dut0", recs_a.size(), 0);
        chk("post_reset_norec_dut1", recs_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
